// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM states, request/response
// records and the address/byte-enable error check.
package mem_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic                      we;
        logic [31:0]               addr;
        logic [31:0]               wdata;
        logic [WORD_BYTES-1:0]     be;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

    // Out-of-range word index or an empty byte mask rejects the request.
    function automatic logic req_error(input mem_req_t r, input int unsigned depth_words);
        return ({2'b00, r.addr[31:2]} >= depth_words) || (r.be == '0);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store request/response bus between core (master) and
// data memory (slave).
interface dmem_responder_if
    import mem_pkg::*;
;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic [WORD_BYTES-1:0] req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word array with per-byte write enables and a
// registered read port; contents are never reset.
module dmem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [WORD_BYTES-1:0] byte_we,
    input  logic [AW-1:0]         addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (byte_we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_STATES cycles,
// performs the access and holds the response until the core consumes it.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    dmem_responder_if.slave bus
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    mem_req_t              req_q, bus_req, acc_req;
    logic                  access, acc_err;
    logic                  err_q, load_ok_q;
    logic [WORD_BYTES-1:0] byte_we;
    logic [31:0]           array_rdata;
    mem_rsp_t              rsp;
    logic                  addr_lsb_unused;

    assign bus_req = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};

    // With no wait states the access fires on the accepting edge, so it must
    // use the live bus fields rather than the not-yet-latched copy.
    assign acc_req         = (state_q == IDLE) ? bus_req : req_q;
    assign acc_err         = req_error(acc_req, DEPTH_WORDS);
    assign byte_we         = (acc_req.we && !acc_err) ? acc_req.be : '0;
    assign addr_lsb_unused = ^acc_req.addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                        access  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && bus.req_valid) begin
                req_q <= bus_req;
            end
            if (access) begin
                err_q     <= acc_err;
                load_ok_q <= !acc_req.we && !acc_err;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .en      (access),
        .byte_we (byte_we),
        .addr    (acc_req.addr[AW+1:2]),
        .wdata   (acc_req.wdata),
        .rdata   (array_rdata)
    );

    // The array output is unreset, so a reset-cleared flag gates it to zero
    // for stores, errors and the post-reset state.
    assign rsp.rdata = load_ok_q ? array_rdata : '0;
    assign rsp.err   = err_q;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp.rdata;
    assign bus.rsp_err   = rsp.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with one wait state and
// one with none, directed load/store vectors with hand-computed responses.
module tb_dmem_responder;
    import mem_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int          WS_A  = 1;
    localparam int          WS_B  = 0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_rsp_t exp_a[$], exp_b[$];
    int       acc_a[$], acc_b[$];
    mem_rsp_t e_a, e_b;
    bit       new_a = 1'b1, new_b = 1'b1;
    int       last_rsp_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            new_a = 1'b1;
        end else begin
            if (bus_a.req_valid && bus_a.req_ready) acc_a.push_back(cyc);
            if (bus_a.rsp_valid) begin
                if (new_a) begin
                    new_a = 1'b0;
                    if (acc_a.size() == 0) flag_fail("lat_a_no_accept");
                    else check("lat_a", cyc, acc_a.pop_front() + 1 + WS_A);
                end
                if (bus_a.rsp_ready) begin
                    if (exp_a.size() == 0) flag_fail("rsp_a_unexpected");
                    else begin
                        e_a = exp_a.pop_front();
                        check("rdata_a", bus_a.rsp_rdata, e_a.rdata);
                        check("err_a", {31'b0, bus_a.rsp_err}, {31'b0, e_a.err});
                    end
                    new_a = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            new_b = 1'b1;
        end else begin
            if (bus_b.req_valid && bus_b.req_ready) acc_b.push_back(cyc);
            if (bus_b.rsp_valid) begin
                if (new_b) begin
                    new_b = 1'b0;
                    if (acc_b.size() == 0) flag_fail("lat_b_no_accept");
                    else check("lat_b", cyc, acc_b.pop_front() + 1 + WS_B);
                end
                if (bus_b.rsp_ready) begin
                    if (exp_b.size() == 0) flag_fail("rsp_b_unexpected");
                    else begin
                        e_b = exp_b.pop_front();
                        check("rdata_b", bus_b.rsp_rdata, e_b.rdata);
                        check("err_b", {31'b0, bus_b.rsp_err}, {31'b0, e_b.err});
                    end
                    new_b = 1'b1;
                    last_rsp_b = cyc;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic req_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                         input bit expect_rsp, input bit drain);
        int n = 0;
        if (expect_rsp) exp_a.push_back('{rdata: exp_rd, err: exp_err});
        bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_addr = addr;
        bus_a.req_wdata = wdata; bus_a.req_be = be;
        @(negedge clk);
        while (!bus_a.req_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus_a.req_ready) begin
            flag_fail("accept_timeout_a");
            bus_a.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus_a.req_valid = 1'b0; bus_a.req_we = ~we; bus_a.req_addr = 32'hFFFF_FFFC;
        bus_a.req_wdata = 32'h0F0F_0F0F; bus_a.req_be = 4'hF;
        if (drain) begin
            n = 0;
            while (exp_a.size() != 0 && n < 100) begin @(negedge clk); n++; end
            if (exp_a.size() != 0) flag_fail("drain_timeout_a");
            @(posedge clk); #1;
        end
    endtask

    task automatic req_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, output int acc_cyc);
        int n = 0;
        exp_b.push_back('{rdata: exp_rd, err: exp_err});
        bus_b.req_valid = 1'b1; bus_b.req_we = we; bus_b.req_addr = addr;
        bus_b.req_wdata = wdata; bus_b.req_be = 4'hF;
        @(negedge clk);
        while (!bus_b.req_ready && n < 50) begin @(negedge clk); n++; end
        acc_cyc = cyc;
        if (!bus_b.req_ready) begin
            flag_fail("accept_timeout_b");
            bus_b.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus_b.req_valid = 1'b0; bus_b.req_addr = 32'hFFFF_FFFC;
    endtask

    task automatic drain_b();
        int n = 0;
        while (exp_b.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (exp_b.size() != 0) flag_fail("drain_timeout_b");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, cx;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
        bus_a.req_wdata = '0; bus_a.req_be = '0; bus_a.rsp_ready = 1'b1;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
        bus_b.req_wdata = '0; bus_b.req_be = '0; bus_b.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("init_req_ready", {31'b0, bus_a.req_ready}, 32'd1);
        check("init_rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
        check("init_rsp_rdata", bus_a.rsp_rdata, 32'd0);
        check("init_rsp_err", {31'b0, bus_a.rsp_err}, 32'd0);
        @(posedge clk); #1;

        // Full store then load
        req_a(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1);
        req_a(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
        // Partial store: lanes 0 and 2 replaced
        req_a(1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1);
        req_a(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 1'b1, 1'b1);
        req_a(1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, 1'b1, 1'b1);
        // Last word in range, then first word out of range
        req_a(1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1);
        req_a(1'b0, 32'h3FF, 32'h0, 4'h1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1);
        req_a(1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 1'b1);
        req_a(1'b1, 32'h400, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 1'b1, 1'b1);
        // Empty byte mask is rejected and leaves memory untouched
        req_a(1'b1, 32'h30, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1);
        req_a(1'b1, 32'h30, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        req_a(1'b0, 32'h30, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 1'b1);

        // Reset during WAIT abandons an uncommitted store
        req_a(1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1);
        req_a(1'b1, 32'h40, 32'h5555_5555, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
        #1 reset_n = 1'b0;
        @(posedge clk);
        acc_a.delete();
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'b0, bus_a.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, bus_a.rsp_err}, 32'd0);
        @(posedge clk); #1;
        req_a(1'b0, 32'h40, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b1);

        // Backpressure: response held stable for five cycles
        bus_a.rsp_ready = 1'b0;
        req_a(1'b0, 32'h10, 32'h0, 4'h2, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        begin
            int n = 0;
            @(negedge clk);
            while (!bus_a.rsp_valid && n < 50) begin @(negedge clk); n++; end
            if (!bus_a.rsp_valid) flag_fail("bp_rsp_timeout");
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd1);
            check("bp_rsp_rdata", bus_a.rsp_rdata, 32'hDEAD_BEEF);
            check("bp_rsp_err", {31'b0, bus_a.rsp_err}, 32'd0);
            check("bp_req_ready", {31'b0, bus_a.req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 bus_a.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_after_req_ready", {31'b0, bus_a.req_ready}, 32'd1);
        check("bp_after_rsp_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
        check("bp_queue_empty", exp_a.size(), 32'd0);
        @(posedge clk); #1;

        // Zero wait states, back-to-back traffic
        req_b(1'b1, 32'h0, 32'h0101_0101, 32'h0, 1'b0, cx);
        req_b(1'b1, 32'h4, 32'h0202_0202, 32'h0, 1'b0, cx);
        req_b(1'b1, 32'h8, 32'h0303_0303, 32'h0, 1'b0, cx);
        req_b(1'b1, 32'hC, 32'h0404_0404, 32'h0, 1'b0, cx);
        req_b(1'b0, 32'h0, 32'h0, 32'h0101_0101, 1'b0, c0);
        req_b(1'b0, 32'h4, 32'h0, 32'h0202_0202, 1'b0, cx);
        req_b(1'b0, 32'h8, 32'h0, 32'h0303_0303, 1'b0, cx);
        req_b(1'b0, 32'hC, 32'h0, 32'h0404_0404, 1'b0, cx);
        drain_b();
        check("b2b_last_accept_span", cx - c0, 32'd6);
        check("b2b_total_cycles", last_rsp_b - c0 + 1, 32'd8);
        req_b(1'b0, 32'h400, 32'h0, 32'h0, 1'b1, cx);
        drain_b();

        repeat (2) @(posedge clk);
        check("a_queue_empty", exp_a.size(), 32'd0);
        check("b_queue_empty", exp_b.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
